// File: rtl/sata_bist_responder.sv
// sata_bist_responder: device-side loopback for the sata_bist engine.
// Accepts BIST command requests, stores the write stream into a dword
// RAM and sources the read stream back from the same RAM.
module sata_bist_responder #(
    parameter int AW      = 10,
    parameter int ACK_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cmd_dat,
    input  logic        cmd_wr,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic [31:0] s_axis_wr_tdata,
    input  logic [7:0]  s_axis_wr_tuser,
    input  logic        s_axis_wr_tvalid,
    output logic        s_axis_wr_tready,
    output logic [31:0] m_axis_rd_tdata,
    output logic [7:0]  m_axis_rd_tuser,
    output logic        m_axis_rd_tvalid,
    input  logic        m_axis_rd_tready,
    input  logic        inj_err,
    output logic [31:0] wr_cmd_cnt,
    output logic [31:0] rd_cmd_cnt,
    output logic [31:0] len_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_WR,
        S_DRAIN,
        S_RD
    } state_t;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   ram_q;

    state_t        state_q, state_d;
    logic [3:0]    dly_q, dly_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   num_q, num_d;
    logic [15:0]   beat_q, beat_d;
    logic          tvalid_q, tvalid_d;
    logic          inj_q, inj_d;
    logic          inj_act_q, inj_act_d;
    logic [31:0]   wr_cnt_q, wr_cnt_d;
    logic [31:0]   rd_cnt_q, rd_cnt_d;
    logic [31:0]   len_cnt_q, len_cnt_d;

    logic          we;
    logic          re;
    logic [AW-1:0] raddr;
    logic          rd_acc;
    logic          inj_clr;
    logic          wr_eop;
    logic [15:0]   beat_inc;

    // Address bits above the RAM index and the write sideband other than
    // eop carry no meaning for a loopback RAM.
    logic unused_bits;
    assign unused_bits = &{1'b0, cmd_dat[63:16+AW], s_axis_wr_tuser[7:1]};

    assign rd_acc   = tvalid_q && m_axis_rd_tready;
    assign inj_clr  = rd_acc && inj_act_q;
    assign wr_eop   = s_axis_wr_tuser[0];
    assign beat_inc = beat_q + 16'd1;

    // Next-state, counter and RAM-port decode for the command/data FSM.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        idx_d     = idx_q;
        num_d     = num_q;
        beat_d    = beat_q;
        tvalid_d  = tvalid_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        len_cnt_d = len_cnt_q;
        we        = 1'b0;
        re        = 1'b0;
        raddr     = idx_q + AW'(1);
        // A pending injection survives until the beat that carries it is taken.
        inj_d     = (inj_q && !inj_clr) || inj_err;
        inj_act_d = rd_acc ? 1'b0 : inj_act_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_req) begin
                    state_d = S_WAIT;
                    dly_d   = 4'(ACK_DLY);
                end
            end
            S_WAIT: begin
                if (dly_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            S_ACK: begin
                num_d = cmd_dat[15:0];
                idx_d = cmd_dat[16+AW-1:16];
                if (cmd_dat[15:0] == 16'd0) begin
                    state_d = S_IDLE;
                    if (cmd_wr) begin
                        wr_cnt_d = wr_cnt_q + 32'd1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 32'd1;
                    end
                end else if (cmd_wr) begin
                    state_d = S_WR;
                    beat_d  = 16'd0;
                end else begin
                    // Prefetch the first dword so it is valid right after ack.
                    state_d   = S_RD;
                    re        = 1'b1;
                    raddr     = cmd_dat[16+AW-1:16];
                    tvalid_d  = 1'b1;
                    beat_d    = 16'd1;
                    inj_act_d = inj_d;
                end
            end
            S_WR: begin
                if (s_axis_wr_tvalid) begin
                    we     = 1'b1;
                    idx_d  = idx_q + AW'(1);
                    beat_d = beat_inc;
                    if (wr_eop) begin
                        state_d  = S_IDLE;
                        wr_cnt_d = wr_cnt_q + 32'd1;
                        if (beat_inc != num_q) begin
                            len_cnt_d = len_cnt_q + 32'd1;
                        end
                    end else if (beat_inc == num_q) begin
                        state_d   = S_DRAIN;
                        wr_cnt_d  = wr_cnt_q + 32'd1;
                        len_cnt_d = len_cnt_q + 32'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (s_axis_wr_tvalid && wr_eop) begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (rd_acc) begin
                    if (beat_q == num_q) begin
                        state_d  = S_IDLE;
                        tvalid_d = 1'b0;
                        rd_cnt_d = rd_cnt_q + 32'd1;
                    end else begin
                        re        = 1'b1;
                        idx_d     = idx_q + AW'(1);
                        beat_d    = beat_inc;
                        inj_act_d = inj_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and counter registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dly_q     <= 4'd0;
            idx_q     <= '0;
            num_q     <= 16'd0;
            beat_q    <= 16'd0;
            tvalid_q  <= 1'b0;
            inj_q     <= 1'b0;
            inj_act_q <= 1'b0;
            wr_cnt_q  <= 32'd0;
            rd_cnt_q  <= 32'd0;
            len_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            beat_q    <= beat_d;
            tvalid_q  <= tvalid_d;
            inj_q     <= inj_d;
            inj_act_q <= inj_act_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            len_cnt_q <= len_cnt_d;
        end
    end

    // Dword RAM: synchronous write, registered read that holds during stalls.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx_q] <= s_axis_wr_tdata;
        end
        if (re) begin
            ram_q <= mem[raddr];
        end
    end

    assign cmd_ack          = (state_q == S_ACK);
    assign s_axis_wr_tready = (state_q == S_WR) || (state_q == S_DRAIN);
    assign m_axis_rd_tvalid = tvalid_q;
    assign m_axis_rd_tdata  = tvalid_q ? (ram_q ^ {31'd0, inj_act_q}) : 32'd0;
    assign m_axis_rd_tuser  = tvalid_q ? {2'b00, 4'hF, (beat_q == 16'd1), (beat_q == num_q)}
                                       : 8'd0;
    assign wr_cmd_cnt       = wr_cnt_q;
    assign rd_cmd_cnt       = rd_cnt_q;
    assign len_err_cnt      = len_cnt_q;

endmodule

// File: tb/tb_sata_bist_responder.sv
// Directed bench for sata_bist_responder: write/read loopback, stalls,
// length errors, index wrap, error injection and mid-read reset.
module tb_sata_bist_responder;

    localparam int AW      = 10;
    localparam int ACK_DLY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cmd_dat;
    logic        cmd_wr;
    logic        cmd_req;
    logic        cmd_ack;
    logic [31:0] s_axis_wr_tdata;
    logic [7:0]  s_axis_wr_tuser;
    logic        s_axis_wr_tvalid;
    logic        s_axis_wr_tready;
    logic [31:0] m_axis_rd_tdata;
    logic [7:0]  m_axis_rd_tuser;
    logic        m_axis_rd_tvalid;
    logic        m_axis_rd_tready;
    logic        inj_err;
    logic [31:0] wr_cmd_cnt;
    logic [31:0] rd_cmd_cnt;
    logic [31:0] len_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wdat [16];
    logic [31:0] rexp [16];

    sata_bist_responder #(.AW(AW), .ACK_DLY(ACK_DLY)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_dat          (cmd_dat),
        .cmd_wr           (cmd_wr),
        .cmd_req          (cmd_req),
        .cmd_ack          (cmd_ack),
        .s_axis_wr_tdata  (s_axis_wr_tdata),
        .s_axis_wr_tuser  (s_axis_wr_tuser),
        .s_axis_wr_tvalid (s_axis_wr_tvalid),
        .s_axis_wr_tready (s_axis_wr_tready),
        .m_axis_rd_tdata  (m_axis_rd_tdata),
        .m_axis_rd_tuser  (m_axis_rd_tuser),
        .m_axis_rd_tvalid (m_axis_rd_tvalid),
        .m_axis_rd_tready (m_axis_rd_tready),
        .inj_err          (inj_err),
        .wr_cmd_cnt       (wr_cmd_cnt),
        .rd_cmd_cnt       (rd_cmd_cnt),
        .len_err_cnt      (len_err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input logic [31:0] wr, input logic [31:0] rd, input logic [31:0] le);
        check("wr_cmd_cnt", wr_cmd_cnt, wr);
        check("rd_cmd_cnt", rd_cmd_cnt, rd);
        check("len_err_cnt", len_err_cnt, le);
    endtask

    // Raise a request and wait (bounded) for the single-cycle ack.
    task automatic do_cmd(input logic [47:0] addr, input logic [15:0] num, input logic wr);
        int lat;
        bit got;
        cmd_dat = {addr, num};
        cmd_wr  = wr;
        cmd_req = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            if (cmd_ack) got = 1'b1;
        end
        cmd_req = 1'b0;
        check("ack_seen", {31'd0, got}, 32'd1);
        check("ack_latency", lat, 32'd4);
        tick();
        check("ack_pulse_end", {31'd0, cmd_ack}, 32'd0);
    endtask

    // Send nbeats beats of wdat[] with eop on beat eop_at (1-based).
    task automatic write_pkt(input logic [47:0] addr, input logic [15:0] num,
                             input int nbeats, input int eop_at);
        do_cmd(addr, num, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            s_axis_wr_tvalid = 1'b1;
            s_axis_wr_tdata  = wdat[i];
            s_axis_wr_tuser  = {2'b00, 4'hF, (i == 0), (i == eop_at - 1)};
            check("wr_tready", {31'd0, s_axis_wr_tready}, 32'd1);
            tick();
        end
        s_axis_wr_tvalid = 1'b0;
        s_axis_wr_tuser  = 8'd0;
        check("wr_done_tready", {31'd0, s_axis_wr_tready}, 32'd0);
    endtask

    // Read num beats against rexp[]; mode 1 toggles tready; stop_at>0 returns early.
    task automatic read_pkt(input logic [47:0] addr, input logic [15:0] num,
                            input int mode, input int stop_at);
        int k;
        int lim;
        bit done;
        bit stall_prev;
        logic [31:0] pd;
        logic [7:0]  pu;
        do_cmd(addr, num, 1'b0);
        k = 0;
        done = 1'b0;
        stall_prev = 1'b0;
        pd = 32'd0;
        pu = 8'd0;
        lim = 4 * int'(num) + 20;
        for (int cyc = 0; cyc < lim && !done; cyc++) begin
            m_axis_rd_tready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            if (stall_prev) begin
                check("rd_stall_data", m_axis_rd_tdata, pd);
                check("rd_stall_user", {24'd0, m_axis_rd_tuser}, {24'd0, pu});
            end
            stall_prev = m_axis_rd_tvalid && !m_axis_rd_tready;
            pd = m_axis_rd_tdata;
            pu = m_axis_rd_tuser;
            if (m_axis_rd_tvalid && m_axis_rd_tready) begin
                check("rd_data", m_axis_rd_tdata, rexp[k]);
                check("rd_user", {24'd0, m_axis_rd_tuser},
                      {24'd0, 2'b00, 4'hF, (k == 0), (k == int'(num) - 1)});
                k++;
                if (k == int'(num)) done = 1'b1;
            end
            tick();
            if (stop_at != 0 && k == stop_at) done = 1'b1;
        end
        m_axis_rd_tready = 1'b0;
        if (stop_at == 0) begin
            check("rd_beats", k, {16'd0, num});
            check("rd_end_tvalid", {31'd0, m_axis_rd_tvalid}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_dat = 64'd0;
        cmd_wr = 1'b0;
        cmd_req = 1'b0;
        s_axis_wr_tdata = 32'd0;
        s_axis_wr_tuser = 8'd0;
        s_axis_wr_tvalid = 1'b0;
        m_axis_rd_tready = 1'b0;
        inj_err = 1'b0;
        tick();
        tick();
        check("rst_ack", {31'd0, cmd_ack}, 32'd0);
        check("rst_tready", {31'd0, s_axis_wr_tready}, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_rd_tvalid}, 32'd0);
        check("rst_tdata", m_axis_rd_tdata, 32'd0);
        check("rst_tuser", {24'd0, m_axis_rd_tuser}, 32'd0);
        check_cnt(32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        tick();

        // Basic write then read at 0x10.
        for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + i;
        write_pkt(48'h10, 16'd4, 4, 4);
        for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + i;
        read_pkt(48'h10, 16'd4, 0, 0);
        check_cnt(32'd1, 32'd1, 32'd0);

        // Eight-beat read with alternating tready.
        for (int i = 0; i < 8; i++) wdat[i] = 32'h1234_5600 + i;
        write_pkt(48'h80, 16'd8, 8, 8);
        for (int i = 0; i < 8; i++) rexp[i] = 32'h1234_5600 + i;
        read_pkt(48'h80, 16'd8, 1, 0);
        check_cnt(32'd2, 32'd2, 32'd0);

        // Short packet: num=4, eop on beat 2.
        wdat[0] = 32'hD0;
        wdat[1] = 32'hD1;
        write_pkt(48'h20, 16'd4, 2, 2);
        check_cnt(32'd3, 32'd2, 32'd1);

        // Long packet over known data: mem[0x42] must keep 0xB2.
        for (int i = 0; i < 4; i++) wdat[i] = 32'hB0 + i;
        write_pkt(48'h40, 16'd4, 4, 4);
        for (int i = 0; i < 5; i++) wdat[i] = 32'hC0 + i;
        write_pkt(48'h40, 16'd2, 5, 5);
        check_cnt(32'd5, 32'd2, 32'd2);
        rexp[0] = 32'hC0;
        rexp[1] = 32'hC1;
        rexp[2] = 32'hB2;
        rexp[3] = 32'hB3;
        read_pkt(48'h40, 16'd4, 0, 0);

        // Index wrap at the top of a 1024-dword RAM.
        for (int i = 0; i < 4; i++) wdat[i] = 32'hE0 + i;
        write_pkt(48'h3FE, 16'd4, 4, 4);
        for (int i = 0; i < 4; i++) rexp[i] = 32'hE0 + i;
        read_pkt(48'h3FE, 16'd4, 0, 0);
        rexp[0] = 32'hE2;
        rexp[1] = 32'hE3;
        read_pkt(48'h0, 16'd2, 0, 0);
        check_cnt(32'd6, 32'd5, 32'd2);

        // Error injection flips bit 0 of the first read beat only.
        for (int i = 0; i < 3; i++) wdat[i] = 32'h55;
        write_pkt(48'h50, 16'd3, 3, 3);
        inj_err = 1'b1;
        tick();
        inj_err = 1'b0;
        rexp[0] = 32'h54;
        rexp[1] = 32'h55;
        rexp[2] = 32'h55;
        read_pkt(48'h50, 16'd3, 0, 0);
        check_cnt(32'd7, 32'd6, 32'd2);

        // Reset in the middle of a six-beat read.
        for (int i = 0; i < 6; i++) wdat[i] = 32'h600 + i;
        write_pkt(48'h100, 16'd6, 6, 6);
        for (int i = 0; i < 6; i++) rexp[i] = 32'h600 + i;
        read_pkt(48'h100, 16'd6, 0, 2);
        check("pre_rst_tvalid", {31'd0, m_axis_rd_tvalid}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_tvalid", {31'd0, m_axis_rd_tvalid}, 32'd0);
        check("async_rst_tdata", m_axis_rd_tdata, 32'd0);
        check_cnt(32'd0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Zero-length read: ack only, no beats.
        do_cmd(48'h100, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("zero_len_tvalid", {31'd0, m_axis_rd_tvalid}, 32'd0);
            tick();
        end
        check_cnt(32'd0, 32'd1, 32'd0);

        // RAM survives reset.
        read_pkt(48'h100, 16'd6, 0, 0);
        check_cnt(32'd0, 32'd2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sata_bist_responder.md
Name: sata_bist_responder

Overview:
- Device-side counterpart of sata_bist: accepts its 64-bit command requests and sinks the write stream into an internal dword RAM.
- Sources the read stream back from that RAM, giving a closed loop the BIST can run against in simulation and FPGA bring-up without a real SATA link.
- Sits where the SATA transport/command layer would attach; its interfaces mirror the BIST command port and its two AXI-Stream ports.

Parameters:
AW, 10, RAM address width; RAM holds 2**AW dwords.
ACK_DLY, 2, idle cycles between seeing cmd_req and pulsing cmd_ack (0..15).

Ports:
clk  input  1  single clock for all logic
rst  input  1  asynchronous, active-high reset
cmd_dat  input  64  {addr[47:0], num[15:0]}; num in dwords
cmd_wr  input  1  1 = write (host to device), 0 = read
cmd_req  input  1  level request, held by initiator until cmd_ack
cmd_ack  output  1  one-cycle acceptance pulse
s_axis_wr_tdata  input  32  write data from BIST
s_axis_wr_tuser  input  8  {drop,err,keep[3:0],sop,eop}
s_axis_wr_tvalid  input  1  write beat valid
s_axis_wr_tready  output  1  write beat accept
m_axis_rd_tdata  output  32  read data to BIST
m_axis_rd_tuser  output  8  {drop,err,keep[3:0],sop,eop}
m_axis_rd_tvalid  output  1  read beat valid
m_axis_rd_tready  input  1  read beat accept
inj_err  input  1  pulse: invert bit 0 of the next read beat issued
wr_cmd_cnt  output  32  completed write commands
rd_cmd_cnt  output  32  completed read commands
len_err_cnt  output  32  write length mismatches

Behaviour:
- Reset: state IDLE; cmd_ack, tready, tvalid, tdata, tuser and all counters = 0; pending inj_err cleared. RAM contents are not cleared and are retained across rst.
- Reset mid-operation: abort immediately. Any beat in flight is dropped; no counter update.
- Index: idx = addr[AW-1:0]; increments per beat and wraps modulo 2**AW.
- FSM states: IDLE, WAIT, ACK, WR, DRAIN, RD.
- IDLE: on cmd_req=1, go to WAIT and load the delay counter with ACK_DLY.
- WAIT: count down; at 0 go to ACK.
- ACK: cmd_ack=1 for exactly one cycle. Latch cmd_dat and cmd_wr in this same cycle.
  - num=0: no data phase; increment wr_cmd_cnt or rd_cmd_cnt; go to IDLE.
  - num>0: go to WR (cmd_wr=1) or RD (cmd_wr=0).
- cmd_req is ignored outside IDLE. A request still high after the return to IDLE is a new command.
- WR state:
  - s_axis_wr_tready=1.
  - Each tvalid&tready beat writes mem[idx]=tdata and increments the beat count.
  - Beat count == num with eop=1: wr_cmd_cnt++, go to IDLE.
  - eop=1 with beat count < num (short packet): len_err_cnt++, wr_cmd_cnt++, go to IDLE.
  - Beat count == num with eop=0 (long packet): len_err_cnt++, wr_cmd_cnt++, go to DRAIN.
  - tuser drop/err/keep are ignored; full dwords are always written.
- DRAIN: tready=1; beats are discarded without writing RAM; on the eop beat go to IDLE.
- tready=0 in every state except WR and DRAIN.
- RD state:
  - RAM is synchronous-read; prefetch so the first tvalid appears no later than 2 cycles after cmd_ack.
  - Full throughput (one beat per clk) while tready=1.
  - tdata = mem[idx]; tuser = {0,0,4'hF,sop,eop}.
  - sop=1 on beat 1; eop=1 on beat num; num=1 gives sop=eop=1.
  - tdata and tuser are held stable while tvalid&!tready.
  - After the eop beat is accepted: rd_cmd_cnt++, tvalid=0, go to IDLE.
- inj_err: sets a sticky flag; the next read beat issued has bit 0 of tdata inverted; the flag clears when that beat is accepted.
- Read after write to the same addr and num returns identical data (excluding injection).
- Counters wrap at 2**32.

Test Plan:
- Write addr=0x10, num=4, data 0xA0..0xA3, eop on beat 4; then read the same -> cmd_ack 1-cycle pulses; read beats 0xA0..0xA3, sop on beat 1, eop on beat 4, tuser keep=F; wr_cmd_cnt=1, rd_cmd_cnt=1, len_err_cnt=0.
- Read num=8 with m_axis_rd_tready toggling 1010... -> tdata/tuser stable during stalls; exactly 8 beats; no beat lost or duplicated.
- Write num=4 with eop on beat 2 -> len_err_cnt=1; IDLE after beat 2; next command accepted. Write num=2 with eop on beat 5 -> len_err_cnt=2; beats 3-5 drained; mem[addr+2] unchanged.
- AW=10, write addr=0x3FE, num=4 -> RAM words 0x3FE, 0x3FF, 0x000, 0x001 written; read back matches.
- inj_err pulse before read num=3 of 0x55 data -> first beat 0x54, beats 2-3 0x55.
- rst asserted mid-read (beat 2 of 6) -> tvalid=0 the same cycle (async); counters 0; RAM preserved; a subsequent read returns the earlier data; num=0 command -> cmd_ack pulse, no beats, rd_cmd_cnt=1.
